rx_con: RTL
===========

# rx_con

Receive-side buffer controller for the UART link. It takes byte-valid pulses from the UART receiver and writes each received byte into the 15-bit-addressed byte RAM at sequential addresses starting at 0. It stops when the buffer is full and reports completion and overrun. It is the counterpart of the transmit controller, which reads the same RAM back out through the UART transmitter.

## Interface
Parameters:
- ADDR_W, 15: RAM address width.
- DEPTH, 32768: bytes captured before full; 1 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- clk, input, 1: single system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- en_rx, input, 1: capture enable; low clears the session (address back to 0).
- rx_dv, input, 1: one-cycle byte-valid pulse from the UART receiver, synchronous to clk.
- rx_byte, input, 8: received byte, valid when rx_dv=1.
- w_address, output, ADDR_W: RAM write address.
- w_data, output, 8: RAM write data.
- w_en, output, 1: RAM write strobe, one cycle per byte.
- byte_count, output, ADDR_W+1: number of bytes written this session.
- rx_full, output, 1: buffer full (level).
- rx_done, output, 1: one-cycle pulse when the last byte is written.
- overrun, output, 1: sticky flag; a byte was dropped.
- outledRX, output, 1: activity LED, active low; 0 while in WAIT or WRITE.

## Operation
- **States:** IDLE, WAIT, WRITE, FULL.
- **Priority each cycle:** rst_n=0 > en_rx=0 > rx_dv.
- **Reset / en_rx low (synchronous):**
  - next state IDLE;
  - w_address=0, w_data=0, w_en=0, byte_count=0;
  - rx_full=0, rx_done=0, overrun=0, outledRX=1.
  - Applies mid-WRITE too: a pending write strobe is suppressed.
- **IDLE:** en_rx=1 → WAIT. An rx_dv in the same cycle is ignored.
- **WAIT:** rx_dv=1 → latch rx_byte into w_data, go to WRITE.
- **WRITE:** w_en=1 for exactly this cycle, with w_address equal to the current address. In the next cycle:
  - byte_count increments by 1;
  - if byte_count reaches DEPTH: go to FULL, set rx_full=1, pulse rx_done=1 for one cycle, and w_address holds at DEPTH-1;
  - otherwise w_address increments by 1 and the state returns to WAIT.
- **rx_dv in WRITE:** byte dropped, overrun=1. A UART frame is far longer than 2 cycles, so this indicates a fault.
- **FULL:**
  - rx_dv sets overrun=1; no write, no address change.
  - Stays in FULL until en_rx=0 or reset.
- **Arithmetic:** w_address never exceeds DEPTH-1 and never wraps. byte_count saturates at DEPTH.
- **outledRX:** 0 in WAIT/WRITE, 1 in IDLE/FULL.

## Timing
- rx_dv sampled at cycle N (in WAIT):
  - cycle N+1: w_en=1, w_data=byte, w_address=A;
  - cycle N+2: w_en=0, w_address=A+1 (or FULL with rx_done=1).
- Latency from rx_dv to the write strobe is 1 cycle. The minimum accepted rx_dv spacing is 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- en_rx=0 at cycle N → IDLE values visible at N+1.
- en_rx re-asserted → first byte goes to address 0.
- rx_done is high for exactly one cycle per session.

## Test plan
(DEPTH=4 for simulation.)
1. **Reset:** hold rst_n=0 for 3 cycles with random inputs → w_en=0, w_address=0, byte_count=0, rx_full=0, overrun=0, outledRX=1.
2. **Normal capture:** en_rx=1, then 4 rx_dv pulses spaced 10 cycles with bytes 0x11, 0x22, 0x33, 0x44 →
   - RAM writes (0,0x11), (1,0x22), (2,0x33), (3,0x44);
   - each w_en is one cycle, 1 cycle after its rx_dv;
   - rx_done pulses once, 2 cycles after the 4th rx_dv; then rx_full=1, byte_count=4, outledRX=1.
3. **Overflow:** from test 2, apply a 5th rx_dv with 0x55 → no w_en, overrun=1, w_address stays 3.
4. **Back-to-back:** rx_dv on consecutive cycles N, N+1 with 0xAA, 0xBB → only 0xAA written at address 0; overrun=1; byte_count=1.
5. **Abort:**
   - drop en_rx in the WRITE cycle → w_en=0 next cycle, address 0, byte_count=0, overrun cleared;
   - re-enable and send 0x5A → written at address 0.
6. **Idle gating:** rx_dv pulses with en_rx=0, and rx_dv in the first cycle en_rx rises → no writes, byte_count stays 0.

Source files
------------

// File: rtl/rx_con.sv
// Receive-side buffer controller: captures UART receiver bytes into a byte RAM
// at sequential addresses from 0 and reports full, done and overrun.
module rx_con #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_rx,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic [ADDR_W-1:0] w_address,
  output logic [7:0]        w_data,
  output logic              w_en,
  output logic [ADDR_W:0]   byte_count,
  output logic              rx_full,
  output logic              rx_done,
  output logic              overrun,
  output logic              outledRX
);

  // rx_dv is a one-cycle pulse with rx_byte valid in the same cycle; there is
  // no backpressure, so a pulse that cannot be accepted is dropped and flagged.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n || !en_rx) begin
      state      <= IDLE;
      w_address  <= '0;
      w_data     <= '0;
      w_en       <= 1'b0;
      byte_count <= '0;
      rx_full    <= 1'b0;
      rx_done    <= 1'b0;
      overrun    <= 1'b0;
      outledRX   <= 1'b1;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          state    <= WAIT;
          outledRX <= 1'b0;
        end
        WAIT: begin
          if (rx_dv) begin
            w_data <= rx_byte;
            w_en   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          w_en       <= 1'b0;
          byte_count <= byte_count + CNT_ONE;
          if (rx_dv) overrun <= 1'b1;
          // Address holds on the last slot once full so it never wraps.
          if (byte_count + CNT_ONE == DEPTH_C) begin
            state    <= FULL;
            rx_full  <= 1'b1;
            rx_done  <= 1'b1;
            outledRX <= 1'b1;
          end else begin
            w_address <= w_address + ADDR_ONE;
            state     <= WAIT;
          end
        end
        FULL: begin
          if (rx_dv) overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
